serial_frame_rx: RTL and testbench
==================================

# serial_frame_rx

Framed serial receiver that consumes the registered single-bit stream produced by the upstream D flip-flop stage, one bit per `clk`. It detects a start bit and assembles `DATA_W` data bits, LSB first. It optionally checks even parity, checks the stop bit, and presents the completed word on a valid/ready output port backed by a one-entry holding register. Framing, parity and overrun conditions are reported as single-cycle pulses.

## Interface
- `DATA_W`, default 8: number of data bits per frame (legal range 1..16).
- `PARITY_EN`, default 0: 1 inserts one even-parity bit between the data bits and the stop bit.

- `clk`  input  1  single clock; every register updates on posedge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `sin`  input  1  serial line from the upstream flip-flop `q`; idles high.
- `dout`  output  DATA_W  received word.
- `dout_valid`  output  1  `dout` holds an undelivered word.
- `dout_ready`  input  1  consumer accepts `dout` on any edge where `dout_valid && dout_ready`.
- `frame_err`  output  1  one-cycle pulse: the stop bit was sampled as 0.
- `parity_err`  output  1  one-cycle pulse: parity mismatch (only when `PARITY_EN=1`).
- `overrun`  output  1  one-cycle pulse: a good frame was dropped because the holding register was occupied.

## Operation
- Sampling: `sin` is sampled on every posedge. There is no oversampling and no synchronizer inside this block; the upstream flip-flop provides the synchronizing register.
- States:
  - IDLE:
    - `sin==0` -> DATA, bit counter cleared to 0.
    - `sin==1` -> stay in IDLE.
  - DATA:
    - Shift `sin` into bit[counter] and increment the counter.
    - After bit `DATA_W-1` -> PARITY if `PARITY_EN`, else STOP.
  - PARITY: sample the parity bit -> STOP. An even-parity mismatch is recorded internally.
  - STOP:
    - `sin==1` and no recorded parity error -> frame good, deliver, -> IDLE.
    - `sin==1` with a recorded parity error -> pulse `parity_err`, discard the word, -> IDLE.
    - `sin==0` -> pulse `frame_err`, discard the word, -> WAIT_IDLE. `parity_err` is not also pulsed.
  - WAIT_IDLE: stay while `sin==0`; `sin==1` -> IDLE. This state blocks a stuck-low line from being read as repeated start bits.
- Delivery of a good frame:
  - If `!dout_valid`, or `dout_valid && dout_ready` on the same edge: load `dout` and set `dout_valid=1`.
  - Otherwise: keep the old word and pulse `overrun`.
- `dout_valid` clears on an edge with `dout_ready=1` when no new word loads on that edge.
- `dout` is stable while `dout_valid=1`.
- The counter width is `$clog2(DATA_W)` bits or more; no wrap beyond `DATA_W-1`.

## Timing
- Reset (async assert, any state): state IDLE, counter 0, `dout=0`, `dout_valid=0`, `frame_err=parity_err=overrun=0`. A frame in progress is abandoned and a held word is lost.
- Reset release: the first edge with `rst_n=1` samples `sin` in IDLE.
- Start bit sampled at edge E (IDLE):
  - Data bits are sampled at E+1 .. E+DATA_W.
  - The parity bit, if present, is sampled at E+DATA_W+1.
  - The stop bit is sampled at S = E+DATA_W+1+PARITY_EN.
- `dout`/`dout_valid`, or the error/overrun pulse, are visible immediately after edge S; pulses are high for exactly one cycle.
- Back-to-back frames: the next start bit may be sampled at S+1. The minimum frame period is DATA_W+2+PARITY_EN cycles.
- Word acceptance: the word is accepted on the edge with `dout_valid && dout_ready`. `dout_valid` falls after that edge unless a new word loads on it.

## Test plan
- Reset, then send start, 0xA5 LSB-first (1,0,1,0,0,1,0,1), stop=1, with `dout_ready=1` -> after edge S, `dout=0xA5`, `dout_valid=1` for one cycle; no error pulses.
- Send 0x3C then 0xC3 back-to-back with `dout_ready=0` -> `dout=0x3C` held and `overrun` pulses at the second frame's S. Raise `dout_ready` -> `dout_valid` drops next edge; 0xC3 is never presented.
- Send 0x12 with stop=0, then hold `sin=0` for 5 cycles, then `sin=1`, then send 0x01 -> `frame_err` pulses once, no `dout_valid` during the low period, then `dout=0x01` valid.
- With `PARITY_EN=1`:
  - Send 0x07 with parity 1 -> delivered.
  - Send 0x07 with parity 0 -> `parity_err` pulses, no `dout_valid`.
- Word 0x11 pending; second frame 0x22 completes with `dout_ready=1` on edge S -> `dout=0x22`, `dout_valid` stays 1, no `overrun`.
- Assert `rst_n=0` mid-data of a frame and also while `dout_valid=1` -> all outputs 0 immediately, asynchronously. After release, 0x5A is received correctly.

Source files
------------

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit, DATA_W bits LSB first, optional even parity, stop bit.
// Completed words are held in a one-entry valid/ready register; errors are one-cycle pulses.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shift;
  logic              par_bad;
  logic              good;
  logic              load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (!sin) state_nxt = S_DATA;
      S_DATA: begin
        if (cnt == LAST_BIT) begin
          if (PARITY_EN) state_nxt = S_PARITY;
          else           state_nxt = S_STOP;
        end
      end
      S_PARITY:    state_nxt = S_STOP;
      S_STOP:      state_nxt = sin ? S_IDLE : S_WAIT_IDLE;
      S_WAIT_IDLE: if (sin) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // A held word may be replaced on the same edge the consumer takes it.
  assign good = (state == S_STOP) && sin && !par_bad;
  assign load = good && (!dout_valid || dout_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= (state == S_STOP) && !sin;
      parity_err <= (state == S_STOP) && sin && par_bad;
      overrun    <= good && !load;

      if (state == S_IDLE) begin
        cnt     <= '0;
        par_bad <= 1'b0;
      end

      if (state == S_DATA) begin
        shift[cnt] <= sin;
        if (cnt != LAST_BIT) cnt <= cnt + 1'b1;
      end

      // Even parity: data ones plus the parity bit must be even.
      if (state == S_PARITY) par_bad <= (^shift) ^ sin;

      if (load) begin
        dout       <= shift;
        dout_valid <= 1'b1;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed scenarios plus random frames on a no-parity and a
// parity-enabled instance, checked every cycle against a frame-level holding-register model.
module tb_serial_frame_rx;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sin_a = 1'b1, sin_b = 1'b1;
  logic rdy_a = 1'b0, rdy_b = 1'b0;
  logic [W-1:0] dout_a, dout_b;
  logic dv_a, dv_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(W), .PARITY_EN(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .sin(sin_a), .dout(dout_a), .dout_valid(dv_a),
    .dout_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a)
  );

  serial_frame_rx #(.DATA_W(W), .PARITY_EN(1'b1)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .sin(sin_b), .dout(dout_b), .dout_valid(dv_b),
    .dout_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b)
  );

  int errors = 0;
  int checks = 0;
  int sel = 0;
  bit mv[2];
  logic [W-1:0] mw[2];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut=%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  function automatic logic pick(input int mode);
    if (mode == 2) return logic'($urandom % 2);
    return (mode != 0);
  endfunction

  // One bit period on the selected instance; the model tracks the holding register.
  task automatic tick(input logic s, input logic r, input bit is_stop, input bit perr,
                      input logic [W-1:0] word);
    bit eo = 0, ef = 0, ep = 0;
    @(negedge clk);
    if (sel == 0) begin sin_a = s; rdy_a = r; sin_b = 1'b1; rdy_b = 1'b0; end
    else          begin sin_b = s; rdy_b = r; sin_a = 1'b1; rdy_a = 1'b0; end
    @(posedge clk);
    if (is_stop && s && !perr) begin
      if (!mv[sel] || r) begin mv[sel] = 1; mw[sel] = word; end
      else eo = 1;
    end else begin
      if (is_stop) begin
        if (!s) ef = 1;
        else    ep = 1;
      end
      if (mv[sel] && r) mv[sel] = 0;
    end
    #1;
    chk("dout_valid", 16'(sel ? dv_b : dv_a), 16'(mv[sel]));
    if (mv[sel]) chk("dout", 16'(sel ? dout_b : dout_a), 16'(mw[sel]));
    chk("frame_err", 16'(sel ? fe_b : fe_a), 16'(ef));
    chk("parity_err", 16'(sel ? pe_b : pe_a), 16'(ep));
    chk("overrun", 16'(sel ? ov_b : ov_a), 16'(eo));
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit stop, input bit flip,
                            input int rmode, input logic rstop);
    tick(1'b0, pick(rmode), 0, 0, w);
    for (int i = 0; i < W; i++) tick(w[i], pick(rmode), 0, 0, w);
    if (sel == 1) tick((^w) ^ flip, pick(rmode), 0, 0, w);
    tick(stop, rstop, 1, (sel == 1) && flip, w);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) tick(1'b1, r, 0, 0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dv_a"}, 16'(dv_a), 16'h0);
    chk({tag, "_dout_a"}, 16'(dout_a), 16'h0);
    chk({tag, "_pulses_a"}, 16'({fe_a, pe_a, ov_a}), 16'h0);
    chk({tag, "_dv_b"}, 16'(dv_b), 16'h0);
    chk({tag, "_dout_b"}, 16'(dout_b), 16'h0);
    chk({tag, "_pulses_b"}, 16'({fe_b, pe_b, ov_b}), 16'h0);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero(tag);
    mv[0] = 0; mv[1] = 0;
    sin_a = 1'b1; sin_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    mv[0] = 0; mv[1] = 0; mw[0] = '0; mw[1] = '0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single frame, consumer ready
    sel = 0;
    send_frame(8'hA5, 1, 0, 1, 1'b1);
    idle(2, 1'b1);

    // Overrun: second word dropped, first held
    send_frame(8'h3C, 1, 0, 0, 1'b0);
    send_frame(8'hC3, 1, 0, 0, 1'b0);
    idle(1, 1'b0);
    idle(2, 1'b1);

    // Framing error, stuck-low line, recovery
    send_frame(8'h12, 0, 0, 1, 1'b1);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 0, 0, '0);
    idle(1, 1'b1);
    send_frame(8'h01, 1, 0, 1, 1'b0);
    idle(2, 1'b1);

    // Replace a pending word on the accepting edge
    send_frame(8'h11, 1, 0, 0, 1'b0);
    send_frame(8'h22, 1, 0, 0, 1'b1);
    idle(2, 1'b1);

    // Parity instance
    sel = 1;
    send_frame(8'h07, 1, 0, 1, 1'b1);
    idle(1, 1'b1);
    send_frame(8'h07, 1, 1, 1, 1'b1);
    idle(1, 1'b1);
    send_frame(8'h07, 0, 1, 1, 1'b1);
    idle(2, 1'b1);

    // Reset mid-data, and while a word is held
    sel = 0;
    tick(1'b0, 1'b0, 0, 0, '0);
    tick(1'b1, 1'b0, 0, 0, '0);
    tick(1'b0, 1'b0, 0, 0, '0);
    async_reset("rst_mid");
    send_frame(8'h5A, 1, 0, 0, 1'b0);
    sel = 1;
    send_frame(8'h96, 1, 0, 0, 1'b0);
    async_reset("rst_held");
    sel = 0;
    send_frame(8'h5A, 1, 0, 1, 1'b1);
    idle(1, 1'b1);
    sel = 1;
    send_frame(8'h5A, 1, 0, 1, 1'b1);
    idle(1, 1'b1);

    // Random frames with random consumer back-pressure
    for (int n = 0; n < 80; n++) begin
      bit stop, flip;
      sel = int'($urandom % 2);
      stop = ($urandom % 6) != 0;
      flip = (sel == 1) && (($urandom % 5) == 0);
      send_frame(W'($urandom), stop, flip, 2, logic'($urandom % 2));
      idle(int'($urandom_range(2, stop ? 0 : 1)), logic'($urandom % 2));
    end
    idle(2, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "bench timeout");
  end

endmodule
